// File: rtl/kbd_entry_pkg.sv
// Shared keypad scan codes and the number-entry state encoding.
package kbd_entry_pkg;

  // PS/2 set-2 keypad make codes as delivered by kbd_if
  localparam logic [7:0] KP_0            = 8'h70;
  localparam logic [7:0] KP_1            = 8'h69;
  localparam logic [7:0] KP_2            = 8'h72;
  localparam logic [7:0] KP_3            = 8'h7A;
  localparam logic [7:0] KP_4            = 8'h6B;
  localparam logic [7:0] KP_5            = 8'h73;
  localparam logic [7:0] KP_6            = 8'h74;
  localparam logic [7:0] KP_7            = 8'h6C;
  localparam logic [7:0] KP_8            = 8'h75;
  localparam logic [7:0] KP_9            = 8'h7D;
  localparam logic [7:0] KP_STAR         = 8'h7C;
  localparam logic [7:0] KP_MINUS        = 8'h7B;
  localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
  localparam logic [7:0] KP_INVALID      = 8'h00;

  typedef enum logic [1:0] {
    KE_IDLE  = 2'd0,
    KE_HELD  = 2'd1,
    KE_BREAK = 2'd2
  } ke_state_e;

  // Non-digit keys that still count as a press to act on
  function automatic logic is_cmd_code(input logic [7:0] code);
    return (code == KP_STAR) || (code == KP_MINUS);
  endfunction

endpackage

// File: rtl/kbd_entry_digit_decode.sv
// Maps a keypad scan code to its BCD digit value.
module kp_digit_decode
  import kbd_entry_pkg::*;
(
  input  logic [7:0] key_i,
  output logic       is_digit_o,
  output logic [3:0] digit_o
);

  // Lookup from shared keycode constants; anything else is not a digit
  always_comb begin
    is_digit_o = 1'b1;
    digit_o    = 4'd0;
    case (key_i)
      KP_0:    digit_o = 4'd0;
      KP_1:    digit_o = 4'd1;
      KP_2:    digit_o = 4'd2;
      KP_3:    digit_o = 4'd3;
      KP_4:    digit_o = 4'd4;
      KP_5:    digit_o = 4'd5;
      KP_6:    digit_o = 4'd6;
      KP_7:    digit_o = 4'd7;
      KP_8:    digit_o = 4'd8;
      KP_9:    digit_o = 4'd9;
      default: is_digit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/kbd_entry.sv
// Keypad number entry: make/break tracking, signed BCD entry buffer and commit.
module kbd_entry
  import kbd_entry_pkg::*;
#(
  parameter int unsigned DIGITS = 4
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            key,
  input  logic                  key_stb,
  output logic [4*DIGITS-1:0]   entry_bcd,
  output logic                  entry_neg,
  output logic [3:0]            entry_cnt,
  output logic [4*DIGITS-1:0]   value_bcd,
  output logic                  value_neg,
  output logic                  value_stb,
  output logic                  overflow
);

  localparam logic [3:0] DIGITS_CNT = 4'(DIGITS);

  ke_state_e             state_q, state_d;
  logic [7:0]            held_q, held_d;
  logic                  act;
  logic                  key_is_digit;
  logic [3:0]            key_digit;
  logic                  key_is_make;
  logic                  do_digit, do_minus, do_star;
  logic                  entry_zero;
  logic [4*DIGITS-1:0]   entry_shifted;

  logic [4*DIGITS-1:0]   entry_bcd_q, value_bcd_q;
  logic [3:0]            entry_cnt_q;
  logic                  entry_neg_q, value_neg_q, value_stb_q, overflow_q;

  kp_digit_decode u_decode (
    .key_i      (key),
    .is_digit_o (key_is_digit),
    .digit_o    (key_digit)
  );

  assign key_is_make = key_is_digit || is_cmd_code(key);

  // State and held make code; held_code starts as KP_INVALID so nothing matches it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= KE_IDLE;
      held_q  <= KP_INVALID;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  // Make/break tracking: decides whether this strobe is a fresh press to act on
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    act     = 1'b0;
    if (key_stb) begin
      unique case (state_q)
        KE_IDLE: begin
          if (key_is_make) begin
            act     = 1'b1;
            held_d  = key;
            state_d = KE_HELD;
          end else if (key == KP_KEY_RELEASED) begin
            state_d = KE_BREAK;
          end
        end
        KE_HELD: begin
          if (key == KP_KEY_RELEASED) begin
            state_d = KE_BREAK;
          end else if (key_is_make && (key != held_q)) begin
            act    = 1'b1;
            held_d = key;
          end
        end
        KE_BREAK: begin
          state_d = (key == held_q) ? KE_IDLE : KE_HELD;
        end
        default: state_d = KE_IDLE;
      endcase
    end
  end

  // Action decode for the accepted press plus the shifted-in buffer image
  always_comb begin
    do_digit              = act && key_is_digit;
    do_minus              = act && (key == KP_MINUS);
    do_star               = act && (key == KP_STAR);
    entry_zero            = (entry_bcd_q == '0);
    entry_shifted         = entry_bcd_q << 4;
    entry_shifted[3:0]    = key_digit;
  end

  // Entry buffer, sign, overflow and commit registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_bcd_q <= '0;
      entry_neg_q <= 1'b0;
      entry_cnt_q <= 4'd0;
      overflow_q  <= 1'b0;
      value_bcd_q <= '0;
      value_neg_q <= 1'b0;
      value_stb_q <= 1'b0;
    end else begin
      value_stb_q <= do_star;
      if (do_star) begin
        value_bcd_q <= entry_bcd_q;
        value_neg_q <= entry_neg_q && !entry_zero;
        entry_bcd_q <= '0;
        entry_neg_q <= 1'b0;
        entry_cnt_q <= 4'd0;
        overflow_q  <= 1'b0;
      end else if (do_digit) begin
        if (entry_cnt_q < DIGITS_CNT) begin
          entry_bcd_q <= entry_shifted;
          entry_cnt_q <= entry_cnt_q + 4'd1;
        end else begin
          overflow_q  <= 1'b1;
        end
      end else if (do_minus) begin
        entry_neg_q <= !entry_neg_q;
      end
    end
  end

  assign entry_bcd = entry_bcd_q;
  assign entry_neg = entry_neg_q;
  assign entry_cnt = entry_cnt_q;
  assign value_bcd = value_bcd_q;
  assign value_neg = value_neg_q;
  assign value_stb = value_stb_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_kbd_entry.sv
// Self-checking bench for kbd_entry: directed keypad scenarios then random strobes.
module tb_kbd_entry;
  import kbd_entry_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MS_IDLE  = 0;
  localparam int MS_HELD  = 1;
  localparam int MS_BREAK = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    key = 8'h00;
  logic          key_stb = 1'b0;
  logic [W-1:0]  entry_bcd, value_bcd;
  logic          entry_neg, value_neg, value_stb, overflow;
  logic [3:0]    entry_cnt;

  kbd_entry #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .key_stb   (key_stb),
    .entry_bcd (entry_bcd),
    .entry_neg (entry_neg),
    .entry_cnt (entry_cnt),
    .value_bcd (value_bcd),
    .value_neg (value_neg),
    .value_stb (value_stb),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  bit checkEn = 1'b0;

  // Reference model: pressed digits kept as a list, most recent last
  int           mDigits[$];
  bit           mNeg, mOvf, mValNeg, mValStb;
  logic [W-1:0] mValBcd;
  int           mState;
  logic [7:0]   mHeld;
  logic [7:0]   digitCodes [10] = '{KP_0, KP_1, KP_2, KP_3, KP_4,
                                    KP_5, KP_6, KP_7, KP_8, KP_9};

  function automatic int digitOf(input logic [7:0] k);
    for (int i = 0; i < 10; i++) if (digitCodes[i] == k) return i;
    return -1;
  endfunction

  function automatic bit isMake(input logic [7:0] k);
    return (digitOf(k) >= 0) || (k == KP_STAR) || (k == KP_MINUS);
  endfunction

  function automatic logic [W-1:0] packDigits();
    logic [W-1:0] r = '0;
    int n = mDigits.size();
    for (int i = 0; i < n; i++) r[4*i +: 4] = 4'(mDigits[n-1-i]);
    return r;
  endfunction

  function automatic bit allZero();
    foreach (mDigits[i]) if (mDigits[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    mDigits.delete();
    mNeg = 0; mOvf = 0; mValNeg = 0; mValStb = 0; mValBcd = '0;
    mState = MS_IDLE; mHeld = KP_INVALID;
  endtask

  task automatic modelAct(input logic [7:0] k);
    int d = digitOf(k);
    if (d >= 0) begin
      if (mDigits.size() < DIGITS) mDigits.push_back(d);
      else mOvf = 1;
    end else if (k == KP_MINUS) begin
      mNeg = !mNeg;
    end else if (k == KP_STAR) begin
      mValBcd = packDigits();
      mValNeg = mNeg && !allZero();
      mValStb = 1;
      mDigits.delete();
      mNeg = 0;
      mOvf = 0;
    end
  endtask

  // Predicts the effect of the coming clock edge
  task automatic modelStep(input bit stb, input logic [7:0] k);
    mValStb = 0;
    if (stb) begin
      case (mState)
        MS_IDLE: begin
          if (isMake(k)) begin modelAct(k); mHeld = k; mState = MS_HELD; end
          else if (k == KP_KEY_RELEASED) mState = MS_BREAK;
        end
        MS_HELD: begin
          if (k == KP_KEY_RELEASED) mState = MS_BREAK;
          else if (isMake(k) && k != mHeld) begin modelAct(k); mHeld = k; end
        end
        default: mState = (k == mHeld) ? MS_IDLE : MS_HELD;
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("entry_bcd", 32'(entry_bcd), 32'(packDigits()));
      checkOutput("entry_neg", 32'(entry_neg), 32'(mNeg));
      checkOutput("entry_cnt", 32'(entry_cnt), 32'(mDigits.size()));
      checkOutput("value_bcd", 32'(value_bcd), 32'(mValBcd));
      checkOutput("value_neg", 32'(value_neg), 32'(mValNeg));
      checkOutput("value_stb", 32'(value_stb), 32'(mValStb));
      checkOutput("overflow",  32'(overflow),  32'(mOvf));
    end
  end

  task automatic drive(input bit stb, input logic [7:0] k);
    @(negedge clk);
    #1;
    key = k;
    key_stb = stb;
    modelStep(stb, k);
  endtask

  task automatic applyStimulus(input logic [7:0] k);
    drive(1'b1, k);
    drive(1'b0, 8'($urandom));
  endtask

  task automatic pressKey(input logic [7:0] k);
    applyStimulus(k);
    applyStimulus(KP_KEY_RELEASED);
    applyStimulus(k);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    key_stb = 1'b0;
    modelReset();
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_entry_bcd"}, 32'(entry_bcd), 32'h0);
    checkOutput({tag, "_entry_cnt"}, 32'(entry_cnt), 32'h0);
    checkOutput({tag, "_entry_neg"}, 32'(entry_neg), 32'h0);
    checkOutput({tag, "_value_bcd"}, 32'(value_bcd), 32'h0);
    checkOutput({tag, "_value_neg"}, 32'(value_neg), 32'h0);
    checkOutput({tag, "_value_stb"}, 32'(value_stb), 32'h0);
    checkOutput({tag, "_overflow"},  32'(overflow),  32'h0);
    checkOutput({tag, "_state"},     32'(dut.state_q), 32'(KE_IDLE));
  endtask

  initial begin
    int r;
    logic [7:0] k;
    modelReset();
    checkEn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    checkAllZero("reset");

    // Press, typematic repeat, release of "5"
    applyStimulus(KP_5); applyStimulus(KP_5); applyStimulus(KP_5);
    applyStimulus(KP_KEY_RELEASED); applyStimulus(KP_5);
    checkOutput("hold5_entry_bcd", 32'(entry_bcd), 32'h0005);
    checkOutput("hold5_entry_cnt", 32'(entry_cnt), 32'd1);
    checkOutput("hold5_state", 32'(dut.state_q), 32'(KE_IDLE));
    checkOutput("hold5_model_bcd", 32'(packDigits()), 32'h0005);
    checkOutput("hold5_model_state", 32'(mState), 32'(MS_IDLE));
    pressKey(KP_STAR);

    // "1","2","3","-","*"
    pressKey(KP_1); pressKey(KP_2); pressKey(KP_3); pressKey(KP_MINUS);
    applyStimulus(KP_STAR);
    checkOutput("neg123_value_bcd", 32'(value_bcd), 32'h0123);
    checkOutput("neg123_value_neg", 32'(value_neg), 32'd1);
    checkOutput("neg123_value_stb", 32'(value_stb), 32'd1);
    checkOutput("neg123_entry_cnt", 32'(entry_cnt), 32'd0);
    checkOutput("neg123_entry_neg", 32'(entry_neg), 32'd0);
    checkOutput("neg123_model_bcd", 32'(mValBcd), 32'h0123);
    checkOutput("neg123_model_neg", 32'(mValNeg), 32'd1);
    applyStimulus(KP_KEY_RELEASED); applyStimulus(KP_STAR);
    checkOutput("neg123_stb_low", 32'(value_stb), 32'd0);

    // Overflow: five digits into a four-digit buffer
    pressKey(KP_9); pressKey(KP_8); pressKey(KP_7); pressKey(KP_6); pressKey(KP_5);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_entry_bcd", 32'(entry_bcd), 32'h9876);
    checkOutput("ovf_entry_cnt", 32'(entry_cnt), 32'd4);
    checkOutput("ovf_model_flag", 32'(mOvf), 32'd1);
    applyStimulus(KP_STAR);
    checkOutput("ovf_value_bcd", 32'(value_bcd), 32'h9876);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    checkOutput("ovf_value_stb", 32'(value_stb), 32'd1);
    applyStimulus(KP_KEY_RELEASED); applyStimulus(KP_STAR);

    // Minus then commit on empty buffer: no negative zero
    pressKey(KP_MINUS);
    checkOutput("negzero_entry_neg", 32'(entry_neg), 32'd1);
    applyStimulus(KP_STAR);
    checkOutput("negzero_value_bcd", 32'(value_bcd), 32'h0);
    checkOutput("negzero_value_neg", 32'(value_neg), 32'd0);
    checkOutput("negzero_value_stb", 32'(value_stb), 32'd1);
    checkOutput("negzero_model_neg", 32'(mValNeg), 32'd0);
    applyStimulus(KP_KEY_RELEASED); applyStimulus(KP_STAR);

    // Rollover of "1" and "2"
    applyStimulus(KP_1);
    checkOutput("roll_state1", 32'(dut.state_q), 32'(KE_HELD));
    applyStimulus(KP_2);
    checkOutput("roll_state2", 32'(dut.state_q), 32'(KE_HELD));
    applyStimulus(KP_KEY_RELEASED);
    checkOutput("roll_state3", 32'(dut.state_q), 32'(KE_BREAK));
    applyStimulus(KP_1);
    checkOutput("roll_state4", 32'(dut.state_q), 32'(KE_HELD));
    applyStimulus(KP_KEY_RELEASED);
    checkOutput("roll_state5", 32'(dut.state_q), 32'(KE_BREAK));
    applyStimulus(KP_2);
    checkOutput("roll_state6", 32'(dut.state_q), 32'(KE_IDLE));
    checkOutput("roll_entry_bcd", 32'(entry_bcd), 32'h0012);
    checkOutput("roll_entry_cnt", 32'(entry_cnt), 32'd2);
    checkOutput("roll_model_state", 32'(mState), 32'(MS_IDLE));

    // Reset between release prefix and break code
    applyStimulus(KP_5);
    applyStimulus(KP_KEY_RELEASED);
    doReset();
    checkAllZero("midreset");
    applyStimulus(KP_0);
    checkOutput("postreset_entry_cnt", 32'(entry_cnt), 32'd1);
    checkOutput("postreset_entry_bcd", 32'(entry_bcd), 32'h0);
    checkOutput("postreset_state", 32'(dut.state_q), 32'(KE_HELD));

    // Randomized strobes, including back-to-back events and occasional resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        doReset();
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 45)      k = digitCodes[$urandom_range(0, 9)];
        else if (r < 65) k = KP_KEY_RELEASED;
        else if (r < 70) k = KP_MINUS;
        else if (r < 75) k = KP_STAR;
        else if (r < 80) k = KP_INVALID;
        else if (r < 95) k = mHeld;
        else             k = 8'($urandom);
        drive($urandom_range(0, 9) < 6, k);
      end
    end
    drive(1'b0, 8'h00);
    @(negedge clk);
    #1;
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/kbd_entry.md
# kbd_entry

Keypad number-entry stage that sits directly downstream of the PS/2 keypad interface (`kbd_if`). It consumes the filtered scan-code stream and tracks make/break sequences so that each physical key press is acted on exactly once. Digit presses are assembled into a signed multi-digit BCD number. `KP_STAR` commits the number to the downstream datapath and display.

## Interface
Parameters:
- DIGITS, 4, maximum BCD digits held in the entry buffer (1..8)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key  in  8  filtered scan code from the keyboard interface (`KP_0`..`KP_9`, `KP_STAR`, `KP_MINUS`, `KP_KEY_RELEASED`, `KP_INVALID`)
- key_stb  in  1  one-cycle pulse, one per received scan code; `key` is valid in the same cycle
- entry_bcd  out  4*DIGITS  live entry buffer; digit 0 in bits [3:0]
- entry_neg  out  1  live sign flag
- entry_cnt  out  4  number of digits currently in the buffer (0..DIGITS)
- value_bcd  out  4*DIGITS  last committed number
- value_neg  out  1  last committed sign
- value_stb  out  1  one-cycle pulse when value_bcd/value_neg update
- overflow  out  1  sticky: a digit was dropped because the buffer was full; cleared on commit

## Operation
- State machine, three states:
  - IDLE: no key held.
  - HELD: make code stored in held_code.
  - BREAK: `KP_KEY_RELEASED` seen; waiting for the break code.
- Only cycles with key_stb=1 are events. key without key_stb is ignored.
- IDLE:
  - On a valid make code: act on it, store held_code, go to HELD.
  - On `KP_KEY_RELEASED`: go to BREAK.
  - On `KP_INVALID`: stay in IDLE, no action.
- HELD:
  - key == held_code is typematic repeat: ignored.
  - A different valid make code (rollover): act on it, update held_code, stay in HELD.
  - `KP_KEY_RELEASED`: go to BREAK.
  - `KP_INVALID`: ignored.
- BREAK:
  - The next event is consumed with no action, whatever its value (including `KP_INVALID` and `KP_KEY_RELEASED`).
  - If the consumed code == held_code, go to IDLE; otherwise return to HELD (a rollover key is still down).
- Actions:
  - Digit d with entry_cnt < DIGITS: entry_bcd <= {entry_bcd[4*DIGITS-5:0], d}, entry_cnt+1.
  - Digit d with entry_cnt == DIGITS: buffer unchanged, overflow <= 1.
  - `KP_MINUS`: entry_neg toggles. Allowed at any entry_cnt, including 0.
  - `KP_STAR`:
    - value_bcd <= entry_bcd.
    - value_neg <= entry_neg, except that an all-zero entry commits value_neg=0 (no negative zero).
    - value_stb=1.
    - entry_bcd, entry_neg, entry_cnt and overflow are cleared.
    - Commit with entry_cnt=0 is legal and commits 0.
- Digit code mapping (`KP_n` to BCD n) uses the shared keycode constants only. No hard-coded values in this block.

## Timing
- Reset values: state IDLE, held_code=`KP_INVALID`, every output 0.
- Latency: a key_stb in cycle N updates outputs at the clk edge ending cycle N. They are visible in cycle N+1.
- value_stb is high for exactly cycle N+1. Back-to-back commits need separate presses, so value_stb is never high two cycles in a row.
- key_stb on consecutive cycles must be handled with no lost events. The upstream rate is far slower, but this is still required.
- Reset asserted mid-entry or in BREAK: immediate return to reset values. The first event after reset is treated as arriving in IDLE.

## Structure
- Shared package/include (existing keycode include): `KP_*` codes, plus state encodings KE_IDLE, KE_HELD, KE_BREAK.
- One natural sub-module: `kp_digit_decode`, combinational. Maps key to {is_digit, digit[3:0]}.
- All remaining logic lives in kbd_entry: FSM, shift buffer, commit registers.

## Test plan
- Press/hold/release "5": strobes 0x73, 0x73, 0x73, 0xF0, 0x73 -> entry_bcd=0x0005, entry_cnt=1. Repeats and break code are ignored; state ends IDLE.
- Sequence "1","2","3","-","*" (each with F0 + break) -> value_bcd=0x0123, value_neg=1, value_stb one cycle; entry cleared.
- Five digits "9","8","7","6","5" then "*" -> overflow=1 before commit; value_bcd=0x9876; overflow=0 after commit.
- "-" then "*" on an empty buffer -> value_bcd=0, value_neg=0, value_stb pulses.
- Rollover: 0x69, 0x72, 0xF0, 0x69, 0xF0, 0x72 -> entry_bcd=0x0012. State goes HELD, then BREAK, back to HELD, then BREAK, and ends IDLE.
- Reset pulsed between 0xF0 and the break code -> all outputs 0. The following 0x70 is accepted as digit 0: entry_cnt=1.
